// File: rtl/taho_pkg.sv
// Shared constants and sizing helpers for the multi-channel tachometer.
package taho_pkg;

    typedef enum logic {
        GATE_EXT = 1'b0,
        GATE_INT = 1'b1
    } gate_src_e;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_BOTH = 1'b1
    } edge_mode_e;

    function automatic int unsigned gate_cnt_width(input int unsigned cycles);
        return $clog2(cycles);
    endfunction

    // A one-cycle filter still needs a 1-bit counter to exist.
    function automatic int unsigned filt_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/taho_chan.sv
// One tach channel: 2-flop synchroniser, persistence filter, edge detect and
// saturating live counter latched on the gate tick.
module taho_chan
    import taho_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned FILTER_CYCLES = 78
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             taho,
    input  logic             edge_mode,
    input  logic             tick,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt_latched,
    output logic             ovf
);

    localparam int unsigned     FW      = filt_cnt_width(FILTER_CYCLES);
    localparam logic [FW-1:0]   FC_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             sync1;
    logic             sync2;
    logic             f;
    logic             f_d;
    logic [FW-1:0]    fc;
    logic [WIDTH-1:0] cnt;
    logic             sticky;
    logic             ev;
    logic             at_max;

    always_comb begin
        ev     = (edge_mode == EDGE_BOTH) ? (f ^ f_d) : (f & ~f_d);
        at_max = (cnt == CNT_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            f           <= 1'b0;
            f_d         <= 1'b0;
            fc          <= '0;
            cnt         <= '0;
            sticky      <= 1'b0;
            cnt_latched <= '0;
            ovf         <= 1'b0;
        end else begin
            sync1 <= taho;
            sync2 <= sync1;
            f_d   <= f;

            if (sync2 == f) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                f  <= ~f;
                fc <= '0;
            end else begin
                fc <= fc + 1'b1;
            end

            // An event in the tick cycle is folded into the closing window.
            if (clear) begin
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (tick) begin
                cnt_latched <= at_max ? CNT_MAX : cnt + WIDTH'(ev);
                ovf         <= sticky | (ev & at_max);
                cnt         <= '0;
                sticky      <= 1'b0;
            end else if (ev) begin
                if (at_max) begin
                    sticky <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/taho_multi.sv
// Multi-channel tachometer: gate selection (external sec or internal
// counter), mode-change restart, valid strobe and per-channel packing.
module taho_multi
    import taho_pkg::*;
#(
    parameter int unsigned NCH           = 4,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned FILTER_CYCLES = 78,
    parameter int unsigned GATE_CYCLES   = 1000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sec,
    input  logic                 gate_src,
    input  logic                 edge_mode,
    input  logic [NCH-1:0]       taho,
    output logic [NCH*WIDTH-1:0] freq,
    output logic [NCH-1:0]       ovf,
    output logic                 valid
);

    localparam int unsigned   GW        = gate_cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic          sec_d;
    logic          gsrc_d;
    logic [GW-1:0] gcnt;
    logic          mode_chg;
    logic          tick;

    always_comb begin
        mode_chg = gate_src ^ gsrc_d;
        tick     = 1'b0;
        if (!mode_chg) begin
            if (gate_src == GATE_INT) begin
                tick = (gcnt == GATE_LAST);
            end else begin
                tick = sec & ~sec_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sec_d  <= 1'b0;
            gsrc_d <= 1'b0;
            gcnt   <= '0;
            valid  <= 1'b0;
        end else begin
            sec_d  <= sec;
            gsrc_d <= gate_src;
            valid  <= tick;
            if (mode_chg || gcnt == GATE_LAST) begin
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        taho_chan #(
            .WIDTH         (WIDTH),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clock       (clock),
            .reset_n     (reset_n),
            .taho        (taho[k]),
            .edge_mode   (edge_mode),
            .tick        (tick),
            .clear       (mode_chg),
            .cnt_latched (freq[k*WIDTH +: WIDTH]),
            .ovf         (ovf[k])
        );
    end

endmodule

// File: tb/tb_taho_multi.sv
// Self-checking bench for taho_multi: spec-derived vector table, directed
// corner sequences and a cycle-level reference model compared every clock.
module tb_taho_multi;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int FILT  = 4;
    localparam int GATE  = 1000;
    localparam int MAXC  = 255;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 sec;
    logic                 gate_src;
    logic                 edge_mode;
    logic [NCH-1:0]       taho = '0;
    logic [NCH*WIDTH-1:0] freq;
    logic [NCH-1:0]       ovf;
    logic                 valid;

    int checks = 0;
    int errors = 0;

    taho_multi #(
        .NCH           (NCH),
        .WIDTH         (WIDTH),
        .FILTER_CYCLES (FILT),
        .GATE_CYCLES   (GATE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sec       (sec),
        .gate_src  (gate_src),
        .edge_mode (edge_mode),
        .taho      (taho),
        .freq      (freq),
        .ovf       (ovf),
        .valid     (valid)
    );

    always #5 clock = ~clock;

    // Pin waveform generator, driven on the falling edge.
    int hi_w [NCH];
    int lo_w [NCH];
    bit gen_en [NCH];
    bit gen_rnd = 1'b0;
    bit man_taho [NCH];
    int gen_cnt [NCH];

    always @(negedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (!gen_en[c]) begin
                taho[c] = man_taho[c];
            end else if (gen_cnt[c] <= 1) begin
                taho[c] = ~taho[c];
                if (gen_rnd) gen_cnt[c] = $urandom_range(1, 12);
                else         gen_cnt[c] = taho[c] ? hi_w[c] : lo_w[c];
            end else begin
                gen_cnt[c] = gen_cnt[c] - 1;
            end
        end
    end

    // Reference model: a level is accepted once the last FILT synchronised
    // samples all disagree with it; counts are plain saturating integers.
    int m_phase;
    bit m_secp, m_gsp, m_valid;
    bit sd1 [NCH];
    bit sd2 [NCH];
    bit mf [NCH];
    bit mfd [NCH];
    bit win [NCH][FILT];
    int mcnt [NCH];
    bit mst [NCH];
    int mfreq [NCH];
    bit movf [NCH];

    always @(posedge clock) begin : model
        bit mc, tk, ev, all_diff;
        if (!reset_n) begin
            m_phase = 0; m_secp = 0; m_gsp = 0; m_valid = 0;
            for (int c = 0; c < NCH; c++) begin
                sd1[c] = 0; sd2[c] = 0; mf[c] = 0; mfd[c] = 0;
                mcnt[c] = 0; mst[c] = 0; mfreq[c] = 0; movf[c] = 0;
                for (int i = 0; i < FILT; i++) win[c][i] = 0;
            end
        end else begin
            mc = (gate_src != m_gsp);
            tk = !mc && (gate_src ? (m_phase == GATE - 1) : (sec && !m_secp));
            for (int c = 0; c < NCH; c++) begin
                ev = edge_mode ? (mf[c] ^ mfd[c]) : (mf[c] && !mfd[c]);
                if (mc) begin
                    mcnt[c] = 0; mst[c] = 0;
                end else if (tk) begin
                    mfreq[c] = (mcnt[c] + int'(ev) > MAXC) ? MAXC : mcnt[c] + int'(ev);
                    movf[c]  = mst[c] || (ev && mcnt[c] == MAXC);
                    mcnt[c]  = 0; mst[c] = 0;
                end else if (ev) begin
                    if (mcnt[c] == MAXC) mst[c] = 1;
                    else mcnt[c] = mcnt[c] + 1;
                end
                for (int i = FILT - 1; i > 0; i--) win[c][i] = win[c][i-1];
                win[c][0] = sd2[c];
                mfd[c] = mf[c];
                all_diff = 1;
                for (int i = 0; i < FILT; i++) if (win[c][i] == mf[c]) all_diff = 0;
                if (all_diff) mf[c] = !mf[c];
                sd2[c] = sd1[c];
                sd1[c] = taho[c];
            end
            m_phase = mc ? 0 : ((m_phase == GATE - 1) ? 0 : m_phase + 1);
            m_valid = tk; m_secp = sec; m_gsp = gate_src;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 2 time units after the edge.
    task automatic step();
        logic [NCH*WIDTH-1:0] ef;
        logic [NCH-1:0]       eo;
        @(posedge clock);
        #2;
        for (int c = 0; c < NCH; c++) begin
            ef[c*WIDTH +: WIDTH] = mfreq[c][WIDTH-1:0];
            eo[c] = movf[c];
        end
        chk("model_valid", valid, m_valid);
        chk("model_freq", freq, ef);
        chk("model_ovf", ovf, eo);
    endtask

    task automatic wait_valid(output int n, input int limit);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < limit);
        if (!valid) chk("valid_timeout", n, -1);
    endtask

    typedef struct {
        string name;
        int    hi;
        int    lo;
        bit    both;
        int    f0;
        bit    o0;
    } vec_t;

    vec_t tbl [8];
    int   n;
    int   nvalid;

    initial begin
        tbl[0] = '{"rise_10_10",  10, 10, 1'b0,  50, 1'b0};
        tbl[1] = '{"both_10_10",  10, 10, 1'b1, 100, 1'b0};
        tbl[2] = '{"glitch_3_10",  3, 10, 1'b0,   0, 1'b0};
        tbl[3] = '{"rise_4_4",     4,  4, 1'b0, 125, 1'b0};
        tbl[4] = '{"both_25_25",  25, 25, 1'b1,  40, 1'b0};
        tbl[5] = '{"glitch_2_2",   2,  2, 1'b1,   0, 1'b0};
        tbl[6] = '{"both_5_5",     5,  5, 1'b1, 200, 1'b0};
        tbl[7] = '{"rise_20_30",  20, 30, 1'b0,  20, 1'b0};

        for (int c = 0; c < NCH; c++) begin
            hi_w[c] = 10; lo_w[c] = 10; gen_en[c] = 0; man_taho[c] = 0; gen_cnt[c] = 0;
        end
        reset_n = 0; sec = 0; gate_src = 1; edge_mode = 0;
        step(); step();
        chk("reset_freq", freq, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_valid", valid, 0);
        reset_n = 1;

        // Internal 1000-clock gate; third window is clear of any transient.
        for (int v = 0; v < 8; v++) begin
            hi_w[0] = tbl[v].hi; lo_w[0] = tbl[v].lo; gen_en[0] = 1;
            edge_mode = tbl[v].both;
            repeat (3) wait_valid(n, 3000);
            chk({tbl[v].name, "_freq0"}, freq[WIDTH-1:0], tbl[v].f0);
            chk({tbl[v].name, "_ovf0"}, ovf[0], tbl[v].o0);
            chk({tbl[v].name, "_freq1_idle"}, freq[2*WIDTH-1:WIDTH], 0);
        end

        // Reset mid-window.
        hi_w[0] = 10; lo_w[0] = 10; edge_mode = 0;
        repeat (2) wait_valid(n, 3000);
        repeat (500) step();
        reset_n = 0;
        step();
        chk("midreset_freq", freq, 0);
        chk("midreset_ovf", ovf, 0);
        chk("midreset_valid", valid, 0);
        reset_n = 1;
        // Counted from the reset edge: the first window spans 1000 clocks
        // starting at the first edge with reset released.
        wait_valid(n, 3000);
        chk("reset_first_valid_delay", n, 1001);

        // gate_src toggled away and back at cycle 500 restarts the window.
        wait_valid(n, 3000);
        repeat (500) step();
        gate_src = 0;
        step();
        gate_src = 1;
        wait_valid(n, 3000);
        chk("modechg_valid_delay", n, 1001);
        chk("modechg_freq0", freq[WIDTH-1:0], 50);

        // Event coincident with a sec tick.
        gate_src = 0; gen_en[0] = 0; man_taho[0] = 0;
        repeat (30) step();
        sec = 1; step(); sec = 0;
        repeat (20) step();
        man_taho[0] = 1;
        repeat (6) step();
        sec = 1;
        step();
        chk("coinc_valid", valid, 1);
        chk("coinc_freq0", freq[WIDTH-1:0], 1);
        sec = 0;
        repeat (20) step();
        man_taho[0] = 0;
        repeat (20) step();
        sec = 1;
        step();
        chk("coinc_next_valid", valid, 1);
        chk("coinc_next_freq0", freq[WIDTH-1:0], 0);

        // sec held for 50 clocks gives exactly one valid.
        nvalid = 1;
        for (int i = 0; i < 49; i++) begin step(); if (valid) nvalid++; end
        sec = 0;
        for (int i = 0; i < 100; i++) begin step(); if (valid) nvalid++; end
        chk("sec_wide_valids", nvalid, 1);

        // Saturation over a 3000-clock sec window.
        hi_w[1] = 5; lo_w[1] = 5; gen_en[1] = 1;
        sec = 1; step(); sec = 0;
        repeat (3000) step();
        sec = 1; step(); sec = 0;
        chk("sat_valid", valid, 1);
        chk("sat_freq1", freq[2*WIDTH-1:WIDTH], MAXC);
        chk("sat_ovf1", ovf[1], 1);
        gen_en[1] = 0; man_taho[1] = 0;
        repeat (30) step();
        sec = 1; step(); sec = 0;
        repeat (200) step();
        sec = 1; step(); sec = 0;
        chk("idle_valid", valid, 1);
        chk("idle_freq1", freq[2*WIDTH-1:WIDTH], 0);
        chk("idle_ovf1", ovf[1], 0);

        // Randomised run against the model.
        gen_rnd = 1; gen_en[0] = 1; gen_en[1] = 1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 2499) == 0) gate_src = ~gate_src;
            if ($urandom_range(0, 799) == 0) edge_mode = ~edge_mode;
            sec = ($urandom_range(0, 1199) == 0) || (sec && $urandom_range(0, 2) != 0);
            reset_n = (i != 7000);
            step();
        end
        reset_n = 1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
